// File: rtl/counter.sv
// counter: registered rising-edge counter on a 1-bit event input.
// Saturates at MAX_COUNT (WRAP=0) or wraps to 0 (WRAP=1).
// Optional input synchronizer: define COUNTER_SYNC_EN to insert a
// two-flop synchronizer ahead of edge detection (+2 cycles latency).
module counter #(
    parameter int unsigned MAX_COUNT = 7,
    parameter bit          WRAP      = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [2:0] out
);

    localparam logic [2:0] MAX_V = 3'(MAX_COUNT);

    logic       in_s;
    logic       in_q;
    logic [2:0] out_q;
    logic [2:0] out_d;
    logic       rise;

`ifdef COUNTER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer for the asynchronous event input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in;
`endif

    assign rise = in_s & ~in_q;

    // Next count: step on a detected rising edge, saturate or wrap at MAX.
    always_comb begin
        out_d = out_q;
        if (rise) begin
            if (out_q >= MAX_V) begin
                out_d = WRAP ? '0 : MAX_V;
            end else begin
                out_d = out_q + 3'd1;
            end
        end
    end

    // Edge-detect history and count registers; reset wins over any edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q  <= 1'b0;
            out_q <= '0;
        end else begin
            in_q  <= in_s;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default (saturating, MAX 7) instance plus
// a wrapping MAX 5 instance, checked every cycle against an edge-count model.
module tb_counter;

`ifdef COUNTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic [2:0] out_sat;
    logic [2:0] out_wrap;

    int errors = 0;
    int checks = 0;

    counter u_sat (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (out_sat)
    );

    counter #(.MAX_COUNT(5), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (out_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: number of 0->1 transitions of the sampled input since
    // the last reset clock; outputs are derived from that count arithmetically.
    int unsigned edges = 0;
    bit          prev  = 1'b0;
    bit          armed = 1'b0;
    bit [1:0]    pipe  = 2'b00;

    always @(posedge clk) begin
        bit s;
        if (!reset) begin
            edges = 0;
            prev  = 1'b0;
            pipe  = 2'b00;
            armed = 1'b1;
        end else begin
`ifdef COUNTER_SYNC_EN
            s    = pipe[1];
            pipe = {pipe[0], din};
`else
            s = din;
`endif
            if (s && !prev) edges++;
            prev = s;
        end
    end

    // Every-cycle comparison against the model once a reset has been applied.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            check("model_sat", out_sat, 3'((edges > 7) ? 7 : edges));
            check("model_wrap", out_wrap, 3'(edges % 6));
        end
    end

    task automatic cyc(input logic r, input logic i);
        reset = r;
        din   = i;
        @(posedge clk);
        #2;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b1);
            repeat (LAT) cyc(1'b1, 1'b0);
        end
    endtask

    logic [2:0] wrap_seq [7];

    initial begin
        wrap_seq[0] = 3'd1; wrap_seq[1] = 3'd2; wrap_seq[2] = 3'd3; wrap_seq[3] = 3'd4;
        wrap_seq[4] = 3'd5; wrap_seq[5] = 3'd0; wrap_seq[6] = 3'd1;

        @(negedge clk);

        // Reset with input low
        cyc(1'b0, 1'b0);
        check("reset_sat", out_sat, 3'd0);
        check("reset_wrap", out_wrap, 3'd0);

        // Single edge held high: exactly one increment
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b1);
            if (k == LAT) check("single_edge", out_sat, 3'd1);
        end
        check("held_high", out_sat, 3'd1);

        // Low phase, then second edge
        repeat (6) cyc(1'b1, 1'b0);
        check("low_phase", out_sat, 3'd1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 1'b1);
            if (k == LAT) check("second_edge", out_sat, 3'd2);
        end
        check("second_hold", out_sat, 3'd2);

        // Saturation and wrap sequences from 1-high pulses
        cyc(1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b1);
            repeat (LAT - 1) cyc(1'b1, 1'b0);
            check("sat_seq", out_sat, 3'((k + 1 > 7) ? 7 : k + 1));
            if (k < 7) check("wrap_seq", out_wrap, wrap_seq[k]);
            cyc(1'b1, 1'b0);
        end
        check("sat_hold", out_sat, 3'd7);
        check("wrap_after9", out_wrap, 3'd3);

        // Mid-operation reset while input high, then release with input high
        cyc(1'b0, 1'b0);
        pulses(4);
        check("mid_four", out_sat, 3'd4);
        cyc(1'b0, 1'b1);
        check("mid_reset", out_sat, 3'd0);
        repeat (LAT) cyc(1'b1, 1'b1);
        check("release_high", out_sat, 3'd1);
        check("release_high_wrap", out_wrap, 3'd1);

        // Randomized run: random-length input runs, occasional resets
        for (int n = 0; n < 3000; ) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                cyc(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1, lvl);
                n++;
            end
        end

        repeat (4) cyc(1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
